// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings, error word and grant rule for the fetch/load-store RAM arbiter.
package mem_port_arbiter_pkg;

    localparam logic [2:0] ARB_IDLE     = 3'd0;
    localparam logic [2:0] ARB_GNT_IF   = 3'd1;
    localparam logic [2:0] ARB_GNT_MEM  = 3'd2;
    localparam logic [2:0] ARB_DONE_IF  = 3'd3;
    localparam logic [2:0] ARB_DONE_MEM = 3'd4;

    localparam logic [31:0] ARB_ERR_WORD = 32'hDEAD_BEEF;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // MEM wins unless IF is also waiting and MEM had the previous grant.
    function automatic src_e pick_src(input logic mem_pend, input logic if_pend, input logic last_mem);
        return (mem_pend && (!if_pend || !last_mem)) ? SRC_MEM : SRC_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and RAM-side signals of the arbiter; slave is the arbiter's view, master the surroundings.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              stall_if;
    logic              stall_mem;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;
    logic              bus_err;

    modport slave (
        input  if_req, if_addr, mem_re, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
        output if_rdata, if_done, mem_rdata, mem_done, stall_if, stall_mem,
               ram_req, ram_we, ram_addr, ram_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, mem_re, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
        input  if_rdata, if_done, mem_rdata, mem_done, stall_if, stall_mem,
               ram_req, ram_we, ram_addr, ram_wdata, bus_err
    );

endinterface

// File: rtl/mem_arb_wdog.sv
// Purpose: counts cycles spent waiting for ram_ack; only built with MEM_ARB_TIMEOUT_EN.
// Latency: o_expire is combinational on the TIMEOUT-th counted cycle after i_load.
// Backpressure: none; the arbiter abandons the access on o_expire.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // r_cnt holds the number of waiting cycles already completed.
    assign o_expire = i_count && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one RAM port between fetch and load/store, alternating when both wait (option MEM_ARB_TIMEOUT_EN).
// Latency: request seen in IDLE -> ram_req next cycle -> done pulse the cycle after ram_ack.
// Backpressure: requesters are held via stall_if/stall_mem; ram_req is held until ram_ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    logic [2:0]        r_state;
    logic              r_last_mem;
    logic              r_ram_req;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_done;
    logic              r_mem_done;

    logic w_mem_pend;
    logic w_grant;
    logic w_sel_mem;
    logic w_in_gnt;
    logic w_expire;
    logic w_end;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    assign w_mem_pend = bus.mem_re | bus.mem_we;
    assign w_grant    = (r_state == ARB_IDLE) && (w_mem_pend || bus.if_req);
    assign w_sel_mem  = (pick_src(w_mem_pend, bus.if_req, r_last_mem) == SRC_MEM);
    assign w_in_gnt   = (r_state == ARB_GNT_IF) || (r_state == ARB_GNT_MEM);
    assign w_end      = w_in_gnt && (bus.ram_ack || w_expire);

`ifdef MEM_ARB_TIMEOUT_EN
    logic r_bus_err;

    mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_grant),
        .i_count  (w_in_gnt),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_err <= 1'b0;
        end else if (w_in_gnt && w_expire && !bus.ram_ack) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus.bus_err = r_bus_err;
`else
    assign w_expire    = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ARB_IDLE;
            r_last_mem  <= 1'b0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_ram_req  <= 1'b1;
                        r_last_mem <= w_sel_mem;
                        if (w_sel_mem) begin
                            r_state     <= ARB_GNT_MEM;
                            r_ram_we    <= bus.mem_we;
                            r_ram_addr  <= bus.mem_addr;
                            r_ram_wdata <= bus.mem_wdata;
                        end else begin
                            r_state    <= ARB_GNT_IF;
                            r_ram_we   <= 1'b0;
                            r_ram_addr <= bus.if_addr;
                        end
                    end
                end
                ARB_GNT_IF: begin
                    if (w_end) begin
                        r_state    <= ARB_DONE_IF;
                        r_ram_req  <= 1'b0;
                        r_ram_we   <= 1'b0;
                        r_if_done  <= 1'b1;
                        r_if_rdata <= bus.ram_ack ? bus.ram_rdata : DATA_W'(ARB_ERR_WORD);
                    end
                end
                ARB_GNT_MEM: begin
                    if (w_end) begin
                        r_state    <= ARB_DONE_MEM;
                        r_ram_req  <= 1'b0;
                        r_ram_we   <= 1'b0;
                        r_mem_done <= 1'b1;
                        // A completed store leaves the last load result visible.
                        if (!bus.ram_ack) begin
                            r_mem_rdata <= DATA_W'(ARB_ERR_WORD);
                        end else if (!r_ram_we) begin
                            r_mem_rdata <= bus.ram_rdata;
                        end
                    end
                end
                ARB_DONE_IF, ARB_DONE_MEM: r_state <= ARB_IDLE;
                default:                   r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.ram_req   = r_ram_req;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.if_done   = r_if_done;
    assign bus.mem_done  = r_mem_done;
    assign bus.stall_if  = bus.if_req & ~r_if_done;
    assign bus.stall_mem = w_mem_pend & ~r_mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner-case sequences and two random requesters against a RAM model.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic clk;
    logic rst;
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        bit          is_if;
        bit          re;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
        int          exp_cyc;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    bit          resp_en = 1'b1;
    bit          rand_lat = 1'b0;
    bit          mon_en = 1'b0;
    int          cur_lat = 1;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        resp_ack;
    logic [31:0] resp_rdata;
    logic [31:0] ram [1024];
    gnt_t        grants [$];

    assign bus.ram_ack   = resp_ack | man_ack;
    assign bus.ram_rdata = resp_en ? resp_rdata : man_rdata;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'h5A00_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // RAM model: acks after cur_lat cycles of ram_req, logs every new access.
    initial begin
        int rcnt;
        rcnt = 0;
        resp_ack = 1'b0;
        resp_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) ram[i] = init_word(32'(i * 4));
        ram[4] = 32'h1234_5678;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (resp_en && rst && bus.ram_req) begin
                if (rcnt == 0) begin
                    grants.push_back('{bus.ram_we, bus.ram_addr, bus.ram_wdata});
                    if (rand_lat) cur_lat = $urandom_range(1, 4);
                end
                rcnt++;
                if (rcnt == cur_lat) begin
                    resp_ack = 1'b1;
                    if (bus.ram_we) begin
                        ram[bus.ram_addr[11:2]] = bus.ram_wdata;
                        resp_rdata = 32'hBAD0_0000;
                    end else begin
                        resp_rdata = ram[bus.ram_addr[11:2]];
                    end
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // Per-cycle checks during random traffic: stall definitions and RAM command stability.
    initial begin
        logic        prev_req;
        logic [31:0] prev_addr;
        logic        prev_we;
        prev_req = 1'b0;
        prev_addr = 32'h0;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                chk("mon_stall_if", bus.stall_if, bus.if_req & ~bus.if_done);
                chk("mon_stall_mem", bus.stall_mem, (bus.mem_re | bus.mem_we) & ~bus.mem_done);
                if (prev_req && bus.ram_req) begin
                    chk("mon_addr_stable", bus.ram_addr, prev_addr);
                    chk("mon_we_stable", bus.ram_we, prev_we);
                end
            end
            prev_req = bus.ram_req;
            prev_addr = bus.ram_addr;
            prev_we = bus.ram_we;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "bench timeout");
    end

    task automatic clear_inputs();
        bus.if_req = 1'b0;
        bus.if_addr = 32'h0;
        bus.mem_re = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_addr = 32'h0;
        bus.mem_wdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ram_req"}, bus.ram_req, 0);
        chk({tag, "_ram_we"}, bus.ram_we, 0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 0);
        chk({tag, "_ram_wdata"}, bus.ram_wdata, 0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 0);
        chk({tag, "_mem_rdata"}, bus.mem_rdata, 0);
        chk({tag, "_if_done"}, bus.if_done, 0);
        chk({tag, "_mem_done"}, bus.mem_done, 0);
        chk({tag, "_bus_err"}, bus.bus_err, 0);
        chk({tag, "_stall_if"}, bus.stall_if, 0);
        chk({tag, "_stall_mem"}, bus.stall_mem, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   cyc;
        bit   seen;
        logic stall;
        cur_lat = v.lat;
        grants.delete();
        @(negedge clk);
        if (v.is_if) begin
            bus.if_req = 1'b1;
            bus.if_addr = v.addr;
        end else begin
            bus.mem_re = v.re;
            bus.mem_we = v.we;
            bus.mem_addr = v.addr;
            bus.mem_wdata = v.wdata;
        end
        #1;
        chk({tag, "_stall_start"}, v.is_if ? bus.stall_if : bus.stall_mem, 1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < v.lat + 20) begin
            @(negedge clk);
            cyc++;
            stall = v.is_if ? bus.stall_if : bus.stall_mem;
            if (v.is_if ? bus.if_done : bus.mem_done) seen = 1'b1;
            else chk({tag, "_stall_wait"}, stall, 1);
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_done_cycles"}, cyc, v.exp_cyc);
        chk({tag, "_rdata"}, v.is_if ? bus.if_rdata : bus.mem_rdata, v.exp_rdata);
        chk({tag, "_stall_done"}, stall, 0);
        chk({tag, "_bus_err"}, bus.bus_err, 0);
        clear_inputs();
        chk({tag, "_n_access"}, grants.size(), 1);
        if (grants.size() > 0) begin
            chk({tag, "_ram_we"}, grants[0].we, v.we);
            chk({tag, "_ram_addr"}, grants[0].addr, v.addr);
            if (v.we) chk({tag, "_ram_wdata"}, grants[0].wdata, v.wdata);
        end
    endtask

    task automatic if_driver();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int          cyc;
            bit          seen;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
            bus.if_req = 1'b1;
            bus.if_addr = a;
            cyc = 0;
            seen = 1'b0;
            while (!seen && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (bus.if_done) seen = 1'b1;
            end
            chk("rnd_if_done", seen, 1);
            chk("rnd_if_wait_bound", 32'(cyc <= 12), 1);
            chk("rnd_if_rdata", bus.if_rdata, init_word(a));
            bus.if_req = 1'b0;
        end
    endtask

    task automatic mem_driver();
        logic [31:0] bmod [8];
        logic [31:0] last_rd;
        last_rd = 32'h0;
        for (int i = 0; i < 8; i++) bmod[i] = init_word(32'h800 + 32'(i * 4));
        for (int n = 0; n < 40; n++) begin
            int          idx;
            bit          st;
            logic [31:0] wd;
            int          cyc;
            bit          seen;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            idx = $urandom_range(0, 7);
            st = 1'($urandom_range(0, 1));
            wd = $urandom;
            bus.mem_we = st;
            bus.mem_re = !st || ($urandom_range(0, 3) == 0);
            bus.mem_addr = 32'h800 + 32'(idx * 4);
            bus.mem_wdata = wd;
            cyc = 0;
            seen = 1'b0;
            while (!seen && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (bus.mem_done) seen = 1'b1;
            end
            chk("rnd_mem_done", seen, 1);
            chk("rnd_mem_wait_bound", 32'(cyc <= 12), 1);
            if (st) begin
                chk("rnd_store_rdata_hold", bus.mem_rdata, last_rd);
                bmod[idx] = wd;
            end else begin
                chk("rnd_load_rdata", bus.mem_rdata, bmod[idx]);
                last_rd = bmod[idx];
            end
            bus.mem_re = 1'b0;
            bus.mem_we = 1'b0;
        end
    endtask

    initial begin
        vec_t tbl [8];
        int   cnt;
        int   pulses;
        logic [31:0] rd;
        bit   exp_we [4];
        logic [31:0] exp_addr [4];

        tbl[0] = '{0, 1, 0, 32'h10, 32'h0,         3, 32'h1234_5678, 4};
        tbl[1] = '{1, 0, 0, 32'h20, 32'h0,         1, 32'h5A00_0020, 2};
        tbl[2] = '{0, 0, 1, 32'h44, 32'hA5A5_0001, 2, 32'h1234_5678, 3};
        tbl[3] = '{0, 1, 0, 32'h44, 32'h0,         1, 32'hA5A5_0001, 2};
        tbl[4] = '{1, 0, 0, 32'h44, 32'h0,         4, 32'hA5A5_0001, 5};
        tbl[5] = '{0, 1, 1, 32'h48, 32'h0BAD_F00D, 1, 32'hA5A5_0001, 2};
        tbl[6] = '{0, 1, 0, 32'h48, 32'h0,         2, 32'h0BAD_F00D, 3};
        tbl[7] = '{1, 0, 0, 32'h10, 32'h0,         2, 32'h1234_5678, 3};

        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        chk_reset_outs("rst");
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Both requesters held: grants must alternate starting with MEM.
        do_reset();
        cur_lat = 1;
        grants.delete();
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h30;
        bus.mem_we = 1'b1;
        bus.mem_addr = 32'h34;
        bus.mem_wdata = 32'h7777_0000;
        cnt = 0;
        while (grants.size() < 4 && cnt < 40) begin
            @(negedge clk);
            #2;
            cnt++;
        end
        clear_inputs();
        repeat (6) @(negedge clk);
        chk("alt_n_grants", grants.size(), 4);
        exp_we = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_addr = '{32'h34, 32'h30, 32'h34, 32'h30};
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            chk($sformatf("alt_we%0d", i), grants[i].we, exp_we[i]);
            chk($sformatf("alt_addr%0d", i), grants[i].addr, exp_addr[i]);
            if (exp_we[i]) chk($sformatf("alt_wdata%0d", i), grants[i].wdata, 32'h7777_0000);
        end

        // Fetch flushed one cycle after grant: access completes once, no retry.
        do_reset();
        cur_lat = 3;
        grants.delete();
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h38;
        @(negedge clk);
        bus.if_req = 1'b0;
        pulses = 0;
        rd = 32'h0;
        repeat (12) begin
            @(negedge clk);
            if (bus.if_done) begin
                pulses++;
                rd = bus.if_rdata;
            end
        end
        chk("flush_done_pulses", pulses, 1);
        chk("flush_n_access", grants.size(), 1);
        chk("flush_rdata", rd, init_word(32'h38));

        // Reset in the middle of an access; a late ack must be ignored.
        do_reset();
        resp_en = 1'b0;
        @(negedge clk);
        bus.mem_re = 1'b1;
        bus.mem_addr = 32'h3C;
        @(negedge clk);
        chk("arst_req_before", bus.ram_req, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req_dropped", bus.ram_req, 0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outs("arst");
        @(negedge clk);
        man_ack = 1'b1;
        man_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        man_ack = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_done || bus.if_done || bus.ram_req) pulses++;
        end
        chk("late_ack_ignored", pulses, 0);
        chk("late_ack_mem_rdata", bus.mem_rdata, 0);
        resp_en = 1'b1;

        do_reset();
        rand_lat = 1'b1;
        mon_en = 1'b1;
        fork
            if_driver();
            mem_driver();
        join
        mon_en = 1'b0;
        rand_lat = 1'b0;
        repeat (4) @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack at all: the watchdog ends the access after TIMEOUT cycles.
        do_reset();
        resp_en = 1'b0;
        @(negedge clk);
        bus.mem_re = 1'b1;
        bus.mem_addr = 32'h60;
        cnt = 0;
        pulses = 0;
        rd = 32'h0;
        repeat (20) begin
            @(negedge clk);
            if (bus.ram_req) cnt++;
            if (bus.mem_done) begin
                pulses++;
                rd = bus.mem_rdata;
                bus.mem_re = 1'b0;
            end
        end
        chk("to_req_cycles", cnt, 4);
        chk("to_done_pulses", pulses, 1);
        chk("to_rdata", rd, 32'hDEAD_BEEF);
        chk("to_bus_err", bus.bus_err, 1);
        repeat (5) @(negedge clk);
        chk("to_bus_err_sticky", bus.bus_err, 1);
        do_reset();
        #1;
        chk("to_bus_err_cleared", bus.bus_err, 0);
        resp_en = 1'b1;
`else
        // Very slow RAM: the arbiter simply waits.
        do_reset();
        begin
            vec_t slow;
            slow = '{0, 1, 0, 32'h50, 32'h0, 300, 32'h5A00_0050, 301};
            run_vec(slow, "slow");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
